// File: rtl/argmax_stream.sv
// Streaming N-channel maximum finder: tracks the largest sample over a frame
// of beats and holds one result (value, channel, beat index) for downstream.
module argmax_stream #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned W      = 3,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned BW     = 8,
  localparam int unsigned CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_max,
  output logic [N_CH-1:0]   out_onehot,
  output logic [CW-1:0]     out_ch_idx,
  output logic [BW-1:0]     out_beat_idx,
  output logic [BW-1:0]     out_beats,
  output logic              out_overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [BW-1:0] CNT_MAX = '1;

  state_t        state, next_state;
  logic          accept;
  logic [W-1:0]  beat_max, run_max, max_nxt;
  logic [CW-1:0] beat_ch, run_ch, ch_nxt;
  logic [BW-1:0] run_beat, beat_nxt, cnt, cnt_nxt;
  logic          ovf, ovf_nxt, upd, cnt_sat;

  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_ready = (state != HOLD) && !rst;
  assign accept   = in_valid && in_ready;

  // Per-beat scan: strictly greater wins, so ties keep the lowest channel.
  always_comb begin
    beat_max = in_data[0 +: W];
    beat_ch  = '0;
    for (int unsigned i = 1; i < N_CH; i++) begin
      if (gt(in_data[i*W +: W], beat_max)) begin
        beat_max = in_data[i*W +: W];
        beat_ch  = CW'(i);
      end
    end
  end

  // Running-value update; the first beat of a frame loads unconditionally.
  always_comb begin
    upd      = (state == IDLE) || gt(beat_max, run_max);
    max_nxt  = upd ? beat_max : run_max;
    ch_nxt   = upd ? beat_ch  : run_ch;
    beat_nxt = upd ? cnt      : run_beat;
    cnt_sat  = (cnt == CNT_MAX);
    cnt_nxt  = cnt_sat ? cnt : cnt + BW'(1);
    ovf_nxt  = ((state == IDLE) ? 1'b0 : ovf) | cnt_sat;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && in_last) next_state = HOLD;
      HOLD:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_max      <= '0;
      out_onehot   <= '0;
      out_ch_idx   <= '0;
      out_beat_idx <= '0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
      run_max      <= '0;
      run_ch       <= '0;
      run_beat     <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
    end else begin
      out_valid <= (next_state == HOLD);
      if (accept) begin
        if (in_last) begin
          out_max      <= max_nxt;
          out_onehot   <= N_CH'(1) << ch_nxt;
          out_ch_idx   <= ch_nxt;
          out_beat_idx <= beat_nxt;
          out_beats    <= cnt_nxt;
          out_overflow <= ovf_nxt;
          cnt          <= '0;
          ovf          <= 1'b0;
        end else begin
          run_max  <= max_nxt;
          run_ch   <= ch_nxt;
          run_beat <= beat_nxt;
          cnt      <= cnt_nxt;
          ovf      <= ovf_nxt;
        end
      end
    end
  end

endmodule
